ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It is the send path that complements the existing PS/2 keyboard receiver.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives the open-collector ps2_clk/ps2_data lines through output-enable signals; the top level converts these to tri-states.
- Runs in the clk_sys domain alongside the receiver, which is gated off by tx_busy.

Parameters:
- CLK_HZ, 13000000: clk_sys frequency in Hz.
- INHIBIT_US, 110: time the clock line is held low for request-to-send, in µs.
- TIMEOUT_US, 15000: frame timeout from clock release to ack, in µs.

Ports:
- clk_sys  in  1: system clock.
- reset_n  in  1: asynchronous active-low reset.
- tx_data  in  8: byte to send.
- tx_valid  in  1: send request.
- tx_ready  out  1: block idle, accepts tx_valid.
- tx_busy  out  1: frame in progress; receiver must ignore the bus.
- tx_done  out  1: one-cycle pulse, frame acknowledged by device.
- tx_error  out  1: one-cycle pulse, NACK or timeout.
- ps2_clk_i  in  1: raw PS/2 clock line (async).
- ps2_data_i  in  1: raw PS/2 data line (async).
- ps2_clk_oe  out  1: 1 = pull clock low.
- ps2_data_oe  out  1: 1 = pull data low.

Behaviour:
- Derived constants, computed at elaboration:
  - INH_CYC = CLK_HZ/1000000*INHIBIT_US (1430 at defaults).
  - TO_CYC = CLK_HZ/1000000*TIMEOUT_US (195000; counter 18 bits).
- Reset values:
  - tx_ready=1; tx_busy=0; tx_done=0; tx_error=0; ps2_clk_oe=0; ps2_data_oe=0.
  - State IDLE; counters 0; both 2-FF synchronisers preset to 1.
- Input sync: ps2_clk_i and ps2_data_i each pass through 2 flops.
- fall = previous synced clk 1 AND current synced clk 0. Edge detection adds 3 cycles of latency from the pin.
- tx_ready = (state==IDLE). tx_busy = not IDLE.
- Frame shift register: 10 bits {stop=1, parity, data[7:0]}, LSB first.
  - Parity is odd: parity = ~^tx_data.
- States:
  - IDLE: when tx_valid is sampled high, latch the frame and go to INHIBIT. On the next cycle ps2_clk_oe=1 and the counter is cleared. tx_valid while busy is ignored; there is no queue.
  - INHIBIT: ps2_clk_oe=1. Once counter==INH_CYC-1, assert ps2_data_oe=1 (start bit) with clk_oe still 1 for that cycle, then go to RELEASE.
  - RELEASE: ps2_clk_oe=0, ps2_data_oe held 1. Timeout counter cleared, bit index=0, go to DATA.
  - DATA: on each fall, ps2_data_oe is set the next cycle to ~frame[idx], then idx++.
    - After idx 9 (stop bit, data_oe=0) go to ACK.
    - Data is changed only in response to a fall, never otherwise.
  - ACK: wait for the 11th fall.
    - Synced data==0 at that fall: ack_ok=1.
    - Otherwise: ack_ok=0 (NACK).
    - Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clk==1 AND data==1. Then pulse tx_done (if ack_ok) or tx_error (if not) for exactly one cycle, and return to IDLE with tx_ready=1 in that same cycle.
- Timeout:
  - The timeout counter runs from RELEASE through WAIT_IDLE.
  - Reaching TO_CYC-1 in any of those states: both oe=0, tx_error pulse, go to IDLE.
  - No tx_done is generated on timeout.
- Only one of tx_done/tx_error is ever asserted per frame.
- A device that starts clocking during INHIBIT is ignored; the host wins the bus.
- reset_n low mid-frame: both oe drop to 0 immediately (async), no pulse; the next frame starts clean.
- ps2_clk_oe and ps2_data_oe are registered; no combinational path from inputs to outputs.

Test Plan:
- Send 0xED: the device model clocks at 12.5 kHz and acks.
  - Required: clk_oe high for 1430 cycles, data_oe set at the last inhibit cycle.
  - Line bits after the start bit, LSB first: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - One tx_done pulse; tx_ready returns to 1.
- Send 0x01: parity bit 0 on the line; send 0x00: parity bit 1. Both complete with tx_done.
- Send 0xFF with the device model holding data high at the 11th edge (NACK): tx_error pulses once, tx_done never, both oe=0 afterwards.
- Send 0xF4 with no device clocking after RELEASE: tx_error pulses exactly 195000 cycles after RELEASE, clk_oe=0 and data_oe=0, state IDLE.
- Assert reset_n low after the 4th falling edge of a frame: both oe=0 asynchronously, no pulses. A following 0xF4 frame completes correctly.
- Hold tx_valid high during a frame with a second byte 0xAA: it is ignored while busy and accepted only when tx_ready returns to 1. Exactly two frames are sent in order.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data LSB first, odd parity, stop, then device ack.
// One byte per frame; tx_valid is taken only while tx_ready, nothing is queued while busy.
module ps2_host_tx #(
  parameter int CLK_HZ     = 13000000,
  parameter int INHIBIT_US = 110,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_CYC = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int CW      = $clog2(TO_CYC);

  localparam logic [CW-1:0] INH_PRE  = CW'(INH_CYC - 2);
  localparam logic [CW-1:0] INH_LAST = CW'(INH_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RELEASE,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [9:0]    frame, frame_nxt;
  logic          ack_ok, ack_nxt;
  logic          clk_oe_nxt, data_oe_nxt, done_nxt, err_nxt;
  logic          clk_s1, clk_s2, clk_d, data_s1, data_s2;
  logic          fall;

  assign fall     = clk_d & ~clk_s2;
  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = ~tx_ready;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1      <= 1'b1;
      clk_s2      <= 1'b1;
      clk_d       <= 1'b1;
      data_s1     <= 1'b1;
      data_s2     <= 1'b1;
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      frame       <= '0;
      ack_ok      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      clk_s1      <= ps2_clk_i;
      clk_s2      <= clk_s1;
      clk_d       <= clk_s2;
      data_s1     <= ps2_data_i;
      data_s2     <= data_s1;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      frame       <= frame_nxt;
      ack_ok      <= ack_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
      tx_done     <= done_nxt;
      tx_error    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    frame_nxt   = frame;
    ack_nxt     = ack_ok;
    clk_oe_nxt  = ps2_clk_oe;
    data_oe_nxt = ps2_data_oe;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          frame_nxt   = {1'b1, ~^tx_data, tx_data};
          cnt_nxt     = '0;
          clk_oe_nxt  = 1'b1;
          data_oe_nxt = 1'b0;
          state_nxt   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_nxt = cnt + CW'(1);
        // start bit is registered one cycle early so it overlaps the last inhibit cycle
        if (cnt == INH_PRE) data_oe_nxt = 1'b1;
        if (cnt == INH_LAST) begin
          clk_oe_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = '0;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        cnt_nxt = cnt + CW'(1);
        if (fall) begin
          data_oe_nxt = ~frame[idx];
          idx_nxt     = idx + 4'd1;
          if (idx == 4'd9) state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        cnt_nxt = cnt + CW'(1);
        if (fall) begin
          ack_nxt   = ~data_s2;
          state_nxt = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_nxt = cnt + CW'(1);
        if (clk_s2 && data_s2) begin
          done_nxt  = ack_ok;
          err_nxt   = ~ack_ok;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // a stalled device must not hold the bus forever
    if ((state != ST_IDLE) && (state != ST_INHIBIT) && (cnt == TO_LAST)) begin
      state_nxt   = ST_IDLE;
      clk_oe_nxt  = 1'b0;
      data_oe_nxt = 1'b0;
      done_nxt    = 1'b0;
      err_nxt     = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx with a PS/2 device model on the wire and a pulse-driven scoreboard.
module tb_ps2_host_tx;

  // DUT runs at 1 MHz: 110 us inhibit = 110 cycles, 15 ms timeout = 15000 cycles
  localparam int INH_CYC = 110;
  localparam int TO_CYC  = 15000;
  localparam int HALF    = 40;   // 12.5 kHz device clock
  localparam int BUDGET  = 40000;
  localparam int K_ACK   = 0;
  localparam int K_NACK  = 1;
  localparam int K_TO    = 2;

  typedef struct {
    logic [7:0] b;
    int         kind;
  } exp_t;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       clk_line, data_line;

  logic       dev_clk_hi = 1'b1;
  logic       dev_data_lo = 1'b0;
  logic       dev_busy = 1'b0;
  int         dev_mode = K_ACK;
  int         dev_falls = 0;
  int         dev_frames = 0;
  logic [9:0] cap_bits = '0;
  logic       cap_start = 1'b1;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [9:0] mon_bits;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_pulses = 0;
  int         n_pushed = 0;
  int         cyc = 0;
  int         rel_cyc = 0;
  int         inh_cnt = 0;
  logic       last_doe = 1'b0;
  logic       prev_doe = 1'b0;

  assign clk_line  = ~ps2_clk_oe & dev_clk_hi;
  assign data_line = ~ps2_data_oe & ~dev_data_lo;

  ps2_host_tx #(.CLK_HZ(1000000), .INHIBIT_US(110), .TIMEOUT_US(15000)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_i  (clk_line),
    .ps2_data_i (data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Wire order after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] line_bits(input logic [7:0] b);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  // Device model: reacts to the host releasing the clock with data held low.
  initial begin
    forever begin
      @(negedge ps2_clk_oe);
      #1;
      if (reset_n !== 1'b1 || ps2_data_oe !== 1'b1) continue;
      cap_start = data_line;
      dev_falls = 0;
      dev_frames++;
      if (dev_mode == K_TO) continue;
      dev_busy = 1'b1;
      for (int k = 1; k <= 11; k++) begin
        repeat (HALF) @(negedge clk_sys);
        dev_clk_hi = 1'b0;
        dev_falls  = k;
        repeat (HALF) @(negedge clk_sys);
        dev_clk_hi = 1'b1;
        if (k <= 10) cap_bits[k-1] = data_line;
        if (k == 10 && dev_mode == K_ACK) begin
          repeat (HALF / 2) @(negedge clk_sys);
          dev_data_lo = 1'b1;
        end
      end
      repeat (HALF / 2) @(negedge clk_sys);
      dev_data_lo = 1'b0;
      dev_busy    = 1'b0;
    end
  end

  // Inhibit phase length, start-bit placement, and the release instant.
  always @(negedge clk_sys) begin
    if (reset_n !== 1'b1) begin
      inh_cnt = 0;
    end else if (ps2_clk_oe) begin
      inh_cnt++;
      prev_doe = last_doe;
      last_doe = ps2_data_oe;
    end else if (inh_cnt != 0) begin
      check("inhibit_len", inh_cnt, INH_CYC);
      check("start_on_last_inhibit", last_doe, 1);
      check("start_not_early", prev_doe, 0);
      rel_cyc  = cyc;
      inh_cnt  = 0;
      last_doe = 1'b0;
      prev_doe = 1'b0;
    end
  end

  // Scoreboard: every completion pulse retires the oldest expected frame.
  always @(negedge clk_sys) begin
    if (reset_n === 1'b1 && (tx_done || tx_error)) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, tx_done, tx_error}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_pulse", tx_done, mon_e.kind == K_ACK);
        check("error_pulse", tx_error, mon_e.kind != K_ACK);
        check("ready_with_pulse", tx_ready, 1);
        check("clk_oe_at_end", ps2_clk_oe, 0);
        check("data_oe_at_end", ps2_data_oe, 0);
        check("start_bit", cap_start, 0);
        if (mon_e.kind == K_TO) begin
          check("timeout_latency", cyc - rel_cyc, TO_CYC);
        end else begin
          mon_bits = line_bits(mon_e.b);
          check("frame_bits", cap_bits, mon_bits);
          check("parity_bit", cap_bits[8], mon_bits[8]);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((!tx_ready || dev_busy || exp_q.size() != 0) && n < BUDGET) begin
      @(negedge clk_sys);
      n++;
    end
    check("idle_within_budget", n < BUDGET, 1);
  endtask

  task automatic send(input logic [7:0] b, input int kind);
    wait_idle();
    dev_mode = kind;
    exp_q.push_back('{b: b, kind: kind});
    n_pushed++;
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk_sys);
    tx_valid = 1'b0;
    check("accepted", tx_busy, 1);
  endtask

  initial begin
    logic [7:0] rb;
    int         n;
    int         pulses_before;
    int         frames_before;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    send(8'hED, K_ACK);
    send(8'h01, K_ACK);
    send(8'h00, K_ACK);
    send(8'hFF, K_NACK);
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb, ($urandom_range(0, 3) == 0) ? K_NACK : K_ACK);
    end
    send(8'hF4, K_TO);

    // reset in the middle of a frame
    wait_idle();
    dev_mode  = K_ACK;
    dev_falls = 0;
    tx_data   = 8'h50;
    tx_valid  = 1'b1;
    @(negedge clk_sys);
    tx_valid = 1'b0;
    n = 0;
    while (dev_falls < 4 && n < BUDGET) begin
      @(negedge clk_sys);
      n++;
    end
    check("fourth_fall_seen", n < BUDGET, 1);
    repeat (6) @(negedge clk_sys);
    check("data_oe_before_reset", ps2_data_oe, 1);
    pulses_before = n_pulses;
    #2 reset_n = 1'b0;
    #1;
    check("async_clk_oe", ps2_clk_oe, 0);
    check("async_data_oe", ps2_data_oe, 0);
    check("async_ready", tx_ready, 1);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    wait_idle();
    check("no_pulse_after_reset", n_pulses, pulses_before);
    send(8'hF4, K_ACK);

    // tx_valid held through a frame: second byte waits for tx_ready
    wait_idle();
    frames_before = dev_frames;
    dev_mode = K_ACK;
    rb = 8'($urandom_range(0, 255));
    exp_q.push_back('{b: rb, kind: K_ACK});
    exp_q.push_back('{b: 8'hAA, kind: K_ACK});
    n_pushed += 2;
    tx_data  = rb;
    tx_valid = 1'b1;
    @(negedge clk_sys);
    tx_data = 8'hAA;
    n = 0;
    while (!tx_ready && n < BUDGET) begin
      @(negedge clk_sys);
      n++;
    end
    check("first_of_pair_done", n < BUDGET, 1);
    @(negedge clk_sys);
    tx_valid = 1'b0;
    check("second_accepted", tx_busy, 1);
    wait_idle();
    check("two_frames_sent", dev_frames - frames_before, 2);

    repeat (10) @(negedge clk_sys);
    check("queue_drained", exp_q.size(), 0);
    check("pulse_count", n_pulses, n_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
